fft_butterfly: RTL and testbench

//  Radix-2 DIT butterfly: Y0 = A + W*B, Y1 = A - W*B, complex, signed fixed point Q1.(WIDTH-1).

---
 rtl/fft_butterfly_if.sv | 25 ++
 rtl/fft_butterfly.sv | 131 +++++++++++++
 tb/tb_fft_butterfly.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_butterfly_if.sv
// Handshake and data bundle for the radix-2 butterfly: operand/twiddle input side
// plus the Y0/Y1 result side, each with its own valid/ready pair.
interface fft_butterfly_if #(
  parameter int WIDTH = 16
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] a_re, a_im;
  logic signed [WIDTH-1:0] b_re, b_im;
  logic signed [WIDTH-1:0] tw_re, tw_im;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] y0_re, y0_im;
  logic signed [WIDTH-1:0] y1_re, y1_im;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, tw_re, tw_im, out_ready,
    input  in_ready, out_valid, y0_re, y0_im, y1_re, y1_im
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, tw_re, tw_im, out_ready,
    output in_ready, out_valid, y0_re, y0_im, y1_re, y1_im
  );
endinterface

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly Y0 = A + W*B, Y1 = A - W*B in Q1.(WIDTH-1), with a
// stall-as-a-whole valid/ready pipe, optional 1/2 scaling and a sticky overflow flag.
module fft_butterfly #(
  parameter int WIDTH = 16,
  parameter int SCALE = 1
) (
  input  logic           clk,
  input  logic           rst,
  fft_butterfly_if.slave bus,
  output logic           ovf
);
  localparam int PW = 2 * WIDTH;
  localparam int TW = 2 * WIDTH + 1;
  localparam int SW = WIDTH + 1;

  localparam logic signed [TW-1:0] T_MAX = {{(TW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [TW-1:0] T_MIN = {{(TW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [TW-1:0] RND   = {{(TW-WIDTH+1){1'b0}}, 1'b1, {(WIDTH-2){1'b0}}};
  localparam logic signed [SW-1:0] S_MAX = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] S_MIN = {2'b11, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] sat_t(input logic signed [TW-1:0] x);
    if (x > T_MAX)      return T_MAX[WIDTH-1:0];
    else if (x < T_MIN) return T_MIN[WIDTH-1:0];
    else                return x[WIDTH-1:0];
  endfunction

  function automatic logic clip_t(input logic signed [TW-1:0] x);
    return (x > T_MAX) || (x < T_MIN);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_s(input logic signed [SW-1:0] x);
    if (x > S_MAX)      return S_MAX[WIDTH-1:0];
    else if (x < S_MIN) return S_MIN[WIDTH-1:0];
    else                return x[WIDTH-1:0];
  endfunction

  function automatic logic clip_s(input logic signed [SW-1:0] x);
    return (x > S_MAX) || (x < S_MIN);
  endfunction

  logic adv;
  logic v0, v1, v2;
  logic signed [WIDTH-1:0] a0_re, a0_im, b0_re, b0_im, w0_re, w0_im;
  logic signed [WIDTH-1:0] a1_re, a1_im, a2_re, a2_im;
  logic signed [PW-1:0]    prr, pii, pri, pir;
  logic signed [WIDTH-1:0] t_re, t_im;

  logic signed [TW-1:0]    t_re_w, t_im_w;
  logic signed [WIDTH-1:0] t_re_n, t_im_n;
  logic                    t_clip;
  logic signed [SW-1:0]    s_re, s_im, d_re, d_im;
  logic signed [WIDTH-1:0] y0_re_n, y0_im_n, y1_re_n, y1_im_n;
  logic                    s_clip;

  assign adv         = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    t_re_w = (TW'(prr) - TW'(pii) + RND) >>> (WIDTH - 1);
    t_im_w = (TW'(pri) + TW'(pir) + RND) >>> (WIDTH - 1);
    t_re_n = sat_t(t_re_w);
    t_im_n = sat_t(t_im_w);
    t_clip = v1 && (clip_t(t_re_w) || clip_t(t_im_w));

    s_re = SW'(a2_re) + SW'(t_re);
    s_im = SW'(a2_im) + SW'(t_im);
    d_re = SW'(a2_re) - SW'(t_re);
    d_im = SW'(a2_im) - SW'(t_im);
    // A halved WIDTH+1-bit sum always fits WIDTH bits, so the scaled path never clips.
    if (SCALE != 0) begin
      y0_re_n = s_re[SW-1:1];
      y0_im_n = s_im[SW-1:1];
      y1_re_n = d_re[SW-1:1];
      y1_im_n = d_im[SW-1:1];
      s_clip  = 1'b0;
    end else begin
      y0_re_n = sat_s(s_re);
      y0_im_n = sat_s(s_im);
      y1_re_n = sat_s(d_re);
      y1_im_n = sat_s(d_im);
      s_clip  = v2 && (clip_s(s_re) || clip_s(s_im) || clip_s(d_re) || clip_s(d_im));
    end
  end

  // Operands are captured first so the multipliers see registered inputs;
  // products, twiddled B and the final sums follow, giving three edges to out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0            <= 1'b0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      bus.out_valid <= 1'b0;
      ovf           <= 1'b0;
      bus.y0_re     <= '0;
      bus.y0_im     <= '0;
      bus.y1_re     <= '0;
      bus.y1_im     <= '0;
    end else if (adv) begin
      v0    <= bus.in_valid;
      a0_re <= bus.a_re;
      a0_im <= bus.a_im;
      b0_re <= bus.b_re;
      b0_im <= bus.b_im;
      w0_re <= bus.tw_re;
      w0_im <= bus.tw_im;

      v1    <= v0;
      a1_re <= a0_re;
      a1_im <= a0_im;
      prr   <= PW'(b0_re) * PW'(w0_re);
      pii   <= PW'(b0_im) * PW'(w0_im);
      pri   <= PW'(b0_re) * PW'(w0_im);
      pir   <= PW'(b0_im) * PW'(w0_re);

      v2    <= v1;
      a2_re <= a1_re;
      a2_im <= a1_im;
      t_re  <= t_re_n;
      t_im  <= t_im_n;

      bus.out_valid <= v2;
      bus.y0_re     <= y0_re_n;
      bus.y0_im     <= y0_im_n;
      bus.y1_re     <= y1_re_n;
      bus.y1_im     <= y1_im_n;

      if (t_clip || s_clip) ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fft_butterfly.sv
// Scoreboard bench for fft_butterfly: one unscaled and one scaled instance share
// stimulus and out_ready; a negedge monitor pops and compares each output transfer.
module tb_fft_butterfly;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_butterfly_if #(.WIDTH(16)) bus0 ();
  fft_butterfly_if #(.WIDTH(16)) bus1 ();
  logic ovf0, ovf1;

  fft_butterfly #(.WIDTH(16), .SCALE(0)) u0 (.clk(clk), .rst(rst), .bus(bus0), .ovf(ovf0));
  fft_butterfly #(.WIDTH(16), .SCALE(1)) u1 (.clk(clk), .rst(rst), .bus(bus1), .ovf(ovf1));

  typedef struct {
    logic [63:0] y;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   rnd_ready = 1'b0;
  bit   chk_rdy   = 1'b0;

  always @(posedge clk) cyc++;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int y0r, input int y0i, input int y1r, input int y1i);
    return {y0r[15:0], y0i[15:0], y1r[15:0], y1i[15:0]};
  endfunction

  function automatic logic [15:0] sat16(input longint x);
    if (x > 32767)  return 16'h7fff;
    if (x < -32768) return 16'h8000;
    return x[15:0];
  endfunction

  // Golden arithmetic on wide integers: round-half-up twiddle product, then sum/diff.
  function automatic logic [63:0] model(input int ar, input int ai, input int br, input int bi,
                                        input int wr, input int wi, input bit scale);
    longint tr, ti, sr, si, dr, di;
    logic signed [15:0] t_r, t_i;
    tr  = (longint'(br) * wr - longint'(bi) * wi + 16384) >>> 15;
    ti  = (longint'(br) * wi + longint'(bi) * wr + 16384) >>> 15;
    t_r = sat16(tr);
    t_i = sat16(ti);
    sr  = longint'(ar) + longint'(t_r);
    si  = longint'(ai) + longint'(t_i);
    dr  = longint'(ar) - longint'(t_r);
    di  = longint'(ai) - longint'(t_i);
    if (scale) return {16'(sr >>> 1), 16'(si >>> 1), 16'(dr >>> 1), 16'(di >>> 1)};
    return {sat16(sr), sat16(si), sat16(dr), sat16(di)};
  endfunction

  task automatic take(input int d, input logic [63:0] act);
    exp_t e;
    if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
      n_cmp++;
      n_err++;
      $display("FAIL dut%0d_unexpected: got %h expected no output", d, act);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      cmp($sformatf("dut%0d_y", d), act, e.y);
      if (e.lat) cmp($sformatf("dut%0d_latency", d), 64'(cyc - e.acc), 64'd3);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.out_valid && bus0.out_ready)
        take(0, {bus0.y0_re, bus0.y0_im, bus0.y1_re, bus0.y1_im});
      if (bus1.out_valid && bus1.out_ready)
        take(1, {bus1.y0_re, bus1.y0_im, bus1.y1_re, bus1.y1_im});
      if (chk_rdy) begin
        cmp("dut0_in_ready", 64'(bus0.in_ready), 64'(!(bus0.out_valid && !bus0.out_ready)));
        cmp("dut1_in_ready", 64'(bus1.in_ready), 64'(!(bus1.out_valid && !bus1.out_ready)));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) begin
      logic r;
      r = 1'($urandom_range(0, 1));
      bus0.out_ready = r;
      bus1.out_ready = r;
    end
  end

  task automatic set_ready(input logic r);
    bus0.out_ready = r;
    bus1.out_ready = r;
  endtask

  task automatic drive(input logic v, input int ar, input int ai, input int br, input int bi,
                       input int wr, input int wi);
    bus0.in_valid = v;      bus1.in_valid = v;
    bus0.a_re  = 16'(ar);   bus1.a_re  = 16'(ar);
    bus0.a_im  = 16'(ai);   bus1.a_im  = 16'(ai);
    bus0.b_re  = 16'(br);   bus1.b_re  = 16'(br);
    bus0.b_im  = 16'(bi);   bus1.b_im  = 16'(bi);
    bus0.tw_re = 16'(wr);   bus1.tw_re = 16'(wr);
    bus0.tw_im = 16'(wi);   bus1.tw_im = 16'(wi);
  endtask

  task automatic send(input int ar, input int ai, input int br, input int bi, input int wr,
                      input int wi, input logic [63:0] e0, input logic [63:0] e1, input bit lat);
    logic acc;
    exp_t e;
    acc = 1'b0;
    drive(1'b1, ar, ai, br, bi, wr, wi);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      acc = bus0.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected acceptance within 1000 cycles");
    end else begin
      e.y = e0; e.acc = cyc; e.lat = lat; q0.push_back(e);
      e.y = e1;                           q1.push_back(e);
    end
    drive(1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_drain: got %0d/%0d pending expected 0/0", name, q0.size(), q1.size());
    end
  endtask

  task automatic check_reset_state(input string name);
    cmp({name, "_flags0"}, 64'({bus0.out_valid, ovf0, bus0.in_ready}), 64'b001);
    cmp({name, "_flags1"}, 64'({bus1.out_valid, ovf1, bus1.in_ready}), 64'b001);
    cmp({name, "_y0"}, {bus0.y0_re, bus0.y0_im, bus0.y1_re, bus0.y1_im}, 64'd0);
    cmp({name, "_y1"}, {bus1.y0_re, bus1.y0_im, bus1.y1_re, bus1.y1_im}, 64'd0);
  endtask

  int twr[6] = '{32767, 0, 23170, -23170, -32768, 12540};
  int twi[6] = '{0, -32768, -23170, -23170, 0, -30274};

  initial begin
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    set_ready(1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    // Real-axis twiddle, with latency check on the first vector.
    send(1000, 0, 2000, 0, 32767, 0, pk(3000, 0, -1000, 0), pk(1500, 0, -500, 0), 1'b1);
    drain("t1");
    // Twiddle -j: rounding of -1999.5 lands on -2000.
    send(1000, 0, 2000, 0, 0, -32768, pk(1000, -2000, 1000, 2000),
         pk(500, -1000, 500, 1000), 1'b1);
    drain("t2");
    cmp("ovf0_clean", 64'(ovf0), 64'd0);
    cmp("ovf1_clean", 64'(ovf1), 64'd0);

    // (-1)*(-1) saturates T, and the unscaled sum saturates as well.
    send(32767, 0, -32768, 0, -32768, 0, pk(32767, 0, 0, 0), pk(32767, 0, 0, 0), 1'b0);
    drain("t4");
    cmp("ovf0_sat", 64'(ovf0), 64'd1);
    cmp("ovf1_sat", 64'(ovf1), 64'd1);
    send(1000, 0, 2000, 0, 32767, 0, pk(3000, 0, -1000, 0), pk(1500, 0, -500, 0), 1'b0);
    drain("t4_clean");
    cmp("ovf0_sticky", 64'(ovf0), 64'd1);
    cmp("ovf1_sticky", 64'(ovf1), 64'd1);

    chk_rdy   = 1'b1;
    rnd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int ar, ai, br, bi, wr, wi;
      ar = -14000 + i * 1500;
      ai = 9000 - i * 977;
      br = -16000 + (i * 3111) % 32000;
      bi = 12000 - i * 1300;
      wr = twr[i % 6];
      wi = twi[i % 6];
      send(ar, ai, br, bi, wr, wi, model(ar, ai, br, bi, wr, wi, 1'b0),
           model(ar, ai, br, bi, wr, wi, 1'b1), 1'b0);
    end
    rnd_ready = 1'b0;
    set_ready(1'b1);
    drain("stream");
    chk_rdy = 1'b0;
    cmp("ovf0_stream", 64'(ovf0), 64'd1);
    cmp("ovf1_stream", 64'(ovf1), 64'd1);

    // Reset with three vectors in flight; none of them may ever surface.
    for (int i = 0; i < 3; i++)
      send(1000, 0, 2000, 0, 0, -32768, pk(1000, -2000, 1000, 2000),
           pk(500, -1000, 500, 1000), 1'b0);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("midrst");
    repeat (8) @(posedge clk);
    #1;
    send(1000, 0, 2000, 0, 32767, 0, pk(3000, 0, -1000, 0), pk(1500, 0, -500, 0), 1'b1);
    drain("post_rst");
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
